// File: rtl/fetch_queue_pkg.sv
// Shared bus types and the fetch-stage types used by the instruction fetch front end.
// common holds the core-wide bus structs; pipes holds the fetch pipeline types.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic       valid;
    u64         addr;
    logic [2:0] size;
    logic [7:0] strobe;
    u64         data;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } ibus_resp_t;
endpackage

package pipes;
  import common::*;

  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;
endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched {pc, instr} entries; flush wins over push and pop.
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import common::*;
  import pipes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable gets a default first, so no path infers a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; head_data is forced to 0 while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[tail_q] <= push_data;
  end

  assign head_data = (count_q != '0) ? mem_q[head_q] : '0;
  assign count     = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch sequencer: one ibus request in flight, buffered {pc, instr} output
// with valid/ready, and a redirect port that flushes the buffer and drops stale data.
module fetch_queue
  import common::*;
  import pipes::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   stale_pc_q, stale_pc_d;
  logic [63:0]   new_pc;
  logic [CW-1:0] count, count_after;
  logic          push, pop;
  fetch_entry_t  push_data, head;
  logic          unused_resp;

  assign new_pc      = {redirect_pc[63:2], 2'b00};
  assign pop         = out_valid && out_ready;
  assign push        = (state_q == REQ) && iresp.data_ok && !redirect_valid;
  assign count_after = count - CW'(pop) + CW'(push);
  assign push_data   = '{pc: fetch_pc_q, instr: iresp.data[31:0]};
  assign unused_resp = ^{iresp.addr_ok, iresp.data[63:32]};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      stale_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_pc_q <= stale_pc_d;
    end
  end

  // A request is only (re)issued when the slot it will fill is guaranteed free.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = new_pc;
          state_d    = REQ;
        end else if (count_after < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = new_pc;
          if (!iresp.data_ok) begin
            stale_pc_d = fetch_pc_q;
            state_d    = DISCARD;
          end
        end else if (iresp.data_ok) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          state_d    = (count_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) fetch_pc_d = new_pc;
        if (iresp.data_ok)  state_d    = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bus keeps seeing the abandoned address until its response drains.
  always_comb begin
    ireq       = '0;
    ireq.valid = (state_q != IDLE);
    ireq.addr  = (state_q == DISCARD) ? stale_pc_q : fetch_pc_q;
    out_valid  = (count != '0) && !redirect_valid;
    out_pc     = head.pc;
    out_instr  = head.instr;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=4 instance with hand-computed vectors and a
// DEPTH=2 instance driven with random out_ready and varying latency against an in-order model.
module tb_fetch_queue;
  import common::*;
  import pipes::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset2;
  ibus_req_t   ireq, ireq2;
  ibus_resp_t  iresp, iresp2;
  logic        redirect_valid, redirect_valid2;
  logic [63:0] redirect_pc, redirect_pc2;
  logic        out_valid, out_valid2, out_ready, out_ready2;
  logic [63:0] out_pc, out_pc2;
  logic [31:0] out_instr, out_instr2;

  int n_cmp = 0;
  int n_bad = 0;
  int fixed_lat = 0;
  int wait_cnt = 0;
  int wait_cnt2 = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_queue #(.DEPTH(2), .RESET_PC(RST_PC)) dut2 (
    .clk(clk), .reset(reset2), .ireq(ireq2), .iresp(iresp2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2), .out_instr(out_instr2)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic int lat2(input logic [63:0] a);
    return int'(a[5:2]) * 3 % 4;
  endfunction

  // Memory responders: data_ok once the request has waited its latency.
  always_comb begin
    iresp = '0;
    if (ireq.valid && wait_cnt >= fixed_lat) begin
      iresp.data_ok = 1'b1;
      iresp.data    = {32'hDEAD_BEEF, mem_word(ireq.addr)};
    end
  end

  always @(posedge clk) begin
    if (reset || !ireq.valid || iresp.data_ok) wait_cnt <= 0;
    else                                       wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    iresp2 = '0;
    if (ireq2.valid && wait_cnt2 >= lat2(ireq2.addr)) begin
      iresp2.data_ok = 1'b1;
      iresp2.data    = {32'hCAFE_F00D, mem_word(ireq2.addr)};
    end
  end

  always @(posedge clk) begin
    if (reset2 || !ireq2.valid || iresp2.data_ok) wait_cnt2 <= 0;
    else                                          wait_cnt2 <= wait_cnt2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_pc;
    int          n_deq;
    bit          seen;

    reset = 1'b1; reset2 = 1'b1;
    out_ready = 1'b0; out_ready2 = 1'b0;
    redirect_valid = 1'b0; redirect_valid2 = 1'b0;
    redirect_pc = '0; redirect_pc2 = '0;
    repeat (3) step();

    check("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    check("rst_ireq_addr",  ireq.addr,       RST_PC);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_pc",     out_pc,          64'd0);
    check("rst_out_instr",  64'(out_instr),  64'd0);

    // Zero-wait streaming with decode always ready.
    out_ready = 1'b1; reset = 1'b0;
    settle();
    check("start_idle", 64'(ireq.valid), 64'd0);
    step();
    check("start_req_valid", 64'(ireq.valid), 64'd1);
    check("start_req_addr",  ireq.addr,       RST_PC);
    check("start_out_valid", 64'(out_valid),  64'd0);
    step();
    check("stream0_valid", 64'(out_valid), 64'd1);
    check("stream0_pc",    out_pc,         64'h8000_0000);
    check("stream0_instr", 64'(out_instr), 64'h9357_9BDF);
    step();
    check("stream1_pc",    out_pc,         64'h8000_0004);
    check("stream1_instr", 64'(out_instr), 64'h9357_9BDB);
    step();
    check("stream2_pc",    out_pc,         64'h8000_0008);
    check("stream2_instr", 64'(out_instr), 64'h9357_9BD7);

    // Fill the buffer with decode stalled.
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (4) step();
    check("fill_last_valid", 64'(ireq.valid), 64'd1);
    check("fill_last_addr",  ireq.addr,       64'h8000_000C);
    step();
    check("full_stall", 64'(ireq.valid), 64'd0);
    check("full_head",  out_pc,          RST_PC);
    step();
    check("full_hold", 64'(ireq.valid), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("refill_valid", 64'(ireq.valid), 64'd1);
    check("refill_addr",  ireq.addr,       64'h8000_0010);
    check("refill_head",  out_pc,          64'h8000_0004);

    // Redirect coincident with the data_ok that would fill the buffer.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    settle();
    check("redir_same_out_valid", 64'(out_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    settle();
    check("redir_next_out_valid", 64'(out_valid), 64'd0);
    check("redir_count",          64'(dut.count), 64'd0);
    check("redir_req_valid",      64'(ireq.valid), 64'd1);
    check("redir_req_addr",       ireq.addr,       64'h8000_0300);
    step();
    check("redir_entry_pc",    out_pc,         64'h8000_0300);
    check("redir_entry_instr", 64'(out_instr), 64'h9357_98DF);

    // Misaligned redirect target is forced to a word boundary.
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0203;
    step();
    redirect_valid = 1'b0;
    settle();
    check("align_req_valid", 64'(ireq.valid), 64'd1);
    check("align_req_addr",  ireq.addr,       64'h8000_0200);
    check("align_out_valid", 64'(out_valid),  64'd0);
    step();
    check("align_entry_pc", out_pc, 64'h8000_0200);

    // Three-cycle bus, redirect during the first wait cycle.
    reset = 1'b1;
    step();
    fixed_lat = 3; reset = 1'b0;
    step();
    check("lat_req_addr", ireq.addr, RST_PC);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    settle();
    check("lat_hold_addr1", ireq.addr, RST_PC);
    step();
    check("lat_hold_addr2", ireq.addr, RST_PC);
    step();
    check("lat_hold_addr3",  ireq.addr,       RST_PC);
    check("lat_hold_outval", 64'(out_valid),  64'd0);
    step();
    check("lat_new_valid", 64'(ireq.valid), 64'd1);
    check("lat_new_addr",  ireq.addr,       64'h8000_0100);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = out_valid;
    end
    check("lat_first_valid", 64'(seen),      64'd1);
    check("lat_first_pc",    out_pc,         64'h8000_0100);
    check("lat_first_instr", 64'(out_instr), 64'h9357_9ADF);

    // DEPTH=2 instance: random decode backpressure, varying latency, mid-stream reset.
    reset2 = 1'b0;
    exp_pc = RST_PC;
    n_deq  = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      if (cyc == 150) begin
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        check("sb_rst_out_valid",  64'(out_valid2),  64'd0);
        check("sb_rst_ireq_valid", 64'(ireq2.valid), 64'd0);
        check("sb_rst_ireq_addr",  ireq2.addr,       RST_PC);
        exp_pc = RST_PC;
      end
      out_ready2 = 1'($urandom_range(0, 1));
      settle();
      if (out_valid2 && out_ready2) begin
        check("sb_pc",    out_pc2,         exp_pc);
        check("sb_instr", 64'(out_instr2), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        n_deq++;
      end
    end
    check("sb_progress", 64'(n_deq >= 40), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end with a configurable instruction buffer. Replaces the fixed PC register and fetch register, which stall on every bus wait, with a sequencer that keeps at most one ibus request in flight and buffers up to DEPTH fetched {pc, instr} entries for decode through a valid/ready handshake. Supports a redirect port for branches and exceptions, which flushes buffered entries and discards any stale in-flight response.

## Interface
- DEPTH, 4: buffer entries; power of two, ≥2
- RESET_PC, 64'h8000_0000: first fetch address after reset
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- ireq  out  ibus_req_t  only .valid and .addr are driven; all other fields are 0
- iresp  in  ibus_resp_t  only .data_ok and .data[31:0] are used
- redirect_valid  in  1  single-cycle redirect strobe
- redirect_pc  in  64  new fetch address; bits [1:0] are forced to 0
- out_valid  out  1  head entry available
- out_ready  in  1  decode accepts head
- out_pc  out  64  PC of head entry
- out_instr  out  32  instruction of head entry

## Operation
- Internal state:
  - fetch_pc (64 bits)
  - FSM state: IDLE, REQ or DISCARD
  - circular buffer with head and tail pointers, each $clog2(DEPTH) bits and wrapping modulo DEPTH
  - count, $clog2(DEPTH)+1 bits
- ireq.valid = (state != IDLE); ireq.addr = fetch_pc.
- Bus rule: while ireq.valid is 1, ireq.addr is held stable until data_ok.
- IDLE:
  - moves to REQ when count < DEPTH or redirect_valid is 1.
- REQ, on data_ok without redirect:
  - enqueue {fetch_pc, iresp.data[31:0]}
  - fetch_pc += 4, wrapping modulo 2^64
  - next state is REQ if count_after < DEPTH, else IDLE
  - count_after includes a dequeue in the same cycle.
- REQ, on redirect without data_ok:
  - fetch_pc ← redirect_pc; go to DISCARD.
- REQ, on redirect with data_ok:
  - drop the response; fetch_pc ← redirect_pc; stay in REQ.
- DISCARD:
  - ireq.addr keeps the old address.
  - On data_ok: drop the data and go to REQ at the new fetch_pc.
  - A further redirect only updates fetch_pc; the state stays DISCARD.
- Redirect, in any state: count, head and tail are cleared to 0 at the next edge.
- Overflow is impossible by construction: REQ is entered only with a free slot, and only the single outstanding response can enqueue.
- out_valid = (count != 0) && !redirect_valid. Redirect suppresses the handshake combinationally.
- Dequeue happens on out_valid && out_ready: head advances.
- Simultaneous enqueue and dequeue leaves count unchanged; the pointers advance independently.
- There is no bypass: an enqueued entry is visible on out_* one cycle later.

## Timing
- Reset values:
  - ireq.valid = 0, ireq.addr = RESET_PC
  - out_valid = 0; out_pc and out_instr are 0
  - state = IDLE, count, head and tail = 0, fetch_pc = RESET_PC
- Startup: first cycle after reset deasserts, ireq.valid = 1 with addr = RESET_PC.
- Zero-wait bus (data_ok in the same cycle):
  - one instruction per cycle
  - the first entry reaches out_valid 2 cycles after reset deasserts
- Full buffer: ireq.valid drops the cycle after the DEPTH-th enqueue. It rises again the cycle after the dequeue that frees a slot.
- Redirect with no request pending: the request to redirect_pc is issued the next cycle.
- Redirect with a request pending: the request to redirect_pc is issued the cycle after the stale data_ok.
- Reset asserted mid-operation (including in DISCARD) returns to reset values at the next edge. An outstanding bus response arriving after reset is not tracked; the bus is reset together with the core.

## Structure
- In package pipes:
  - fetch_entry_t {u64 pc; u32 instr}
  - typedef enum fetch_state_t {IDLE, REQ, DISCARD}
- ibus_req_t and ibus_resp_t stay in common.
- Sub-module fetch_fifo (parameter DEPTH):
  - ports: push, push_data, pop, flush, head_data, count
  - flush has priority over push/pop
- fetch_queue holds the FSM and fetch_pc, and instantiates fetch_fifo.

## Test plan
- Zero-wait bus, out_ready = 1, DEPTH = 4: out_pc = 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; out_instr matches memory.
- out_ready = 0, bus always ready: exactly 4 enqueues, then ireq.valid = 0. One dequeue gives ireq.valid = 1 on the next cycle with addr = 8000_0010.
- 3-cycle bus latency, redirect to 8000_0100 in the first wait cycle: ireq.addr stays 8000_0000 until data_ok; that data never appears on out. Next request addr = 8000_0100.
- redirect_valid coincident with data_ok and a full buffer: out_valid = 0 the same cycle and the next. Next ireq.addr = redirect_pc; count = 0.
- redirect_pc = 8000_0203: request issued at 8000_0200.
- DEPTH = 2 with random out_ready and random bus latency against a scoreboard: no drop, duplicate or reorder. Reset asserted mid-stream restarts fetch at RESET_PC.
